// File: rtl/uart_pkg.sv
// Shared UART definitions: default widths, handshake timeout and transmit FSM encoding.
package uart_pkg;

    localparam int UART_DATA_W      = 8;
    localparam int UART_ACK_TIMEOUT = 15;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_LOAD      = 2'd1,
        TX_WAIT_BUSY = 2'd2,
        TX_WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_controller_if.sv
// Host-side write port, FIFO status and uart_tx start/busy handshake of the TX FIFO controller.
interface uart_tx_fifo_controller_if
    import uart_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int ADDR_W = 4
);

    logic              write;
    logic [DATA_W-1:0] data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              tx_busy;
    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              tx_error;

    modport master (
        output write, data, tx_busy,
        input  full, empty, count, overflow, tx_start, tx_data, tx_error
    );

    modport slave (
        input  write, data, tx_busy,
        output full, empty, count, overflow, tx_start, tx_data, tx_error
    );

endinterface

// File: rtl/sync_fifo.sv
// Portable synchronous FIFO with registered read data and registered occupancy flags.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrreq,
    input  logic [DATA_W-1:0] data,
    input  logic              rdreq,
    output logic [DATA_W-1:0] q,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   usedw
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   usedw_q, usedw_d;
    logic [DATA_W-1:0] q_q;
    logic              empty_q, full_q;
    logic              do_wr, do_rd;

    // A read on a full FIFO frees a slot, so a same-edge write is still accepted.
    assign do_rd = rdreq & ~empty_q;
    assign do_wr = wrreq & (~full_q | do_rd);

    always_comb begin
        usedw_d = usedw_q;
        if (do_wr && !do_rd)
            usedw_d = usedw_q + 1'b1;
        else if (!do_wr && do_rd)
            usedw_d = usedw_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_wr)
            mem_q[wr_ptr_q] <= data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
            q_q      <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            if (do_wr)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) begin
                q_q      <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            usedw_q <= usedw_d;
            empty_q <= (usedw_d == '0);
            full_q  <= (usedw_d == (ADDR_W+1)'(DEPTH));
        end
    end

    assign q     = q_q;
    assign empty = empty_q;
    assign full  = full_q;
    assign usedw = usedw_q;

endmodule

// File: rtl/uart_tx_fifo_controller.sv
// Buffers host bytes in a FIFO and feeds them to uart_tx with a start-pulse / busy handshake,
// flagging dropped writes and serializers that never acknowledge.
module uart_tx_fifo_controller
    import uart_pkg::*;
#(
    parameter int DATA_W      = UART_DATA_W,
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int ACK_TIMEOUT = UART_ACK_TIMEOUT
) (
    input logic                        clk,
    input logic                        rst,
    uart_tx_fifo_controller_if.slave   bus
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    tx_state_e         state_q;
    logic [TMR_W-1:0]  timer_q;
    logic              write_q;
    logic              overflow_q;
    logic              tx_start_q;
    logic              tx_error_q;
    logic [DATA_W-1:0] tx_data_q;

    logic              push, pop;
    logic              fifo_empty, fifo_full;
    logic [DATA_W-1:0] fifo_q;
    logic [ADDR_W:0]   fifo_used;

    assign push = bus.write & ~write_q;
    assign pop  = (state_q == TX_IDLE) & ~fifo_empty & ~bus.tx_busy;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wrreq (push),
        .data  (bus.data),
        .rdreq (pop),
        .q     (fifo_q),
        .empty (fifo_empty),
        .full  (fifo_full),
        .usedw (fifo_used)
    );

    // write_q resets high so a write held across reset release is not seen as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            write_q    <= bus.write;
            overflow_q <= push & fifo_full & ~pop;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= TX_IDLE;
            timer_q    <= '0;
            tx_start_q <= 1'b0;
            tx_error_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            tx_error_q <= 1'b0;
            case (state_q)
                TX_IDLE: begin
                    if (pop)
                        state_q <= TX_LOAD;
                end
                TX_LOAD: begin
                    tx_data_q  <= fifo_q;
                    tx_start_q <= 1'b1;
                    timer_q    <= '0;
                    state_q    <= TX_WAIT_BUSY;
                end
                TX_WAIT_BUSY: begin
                    tx_start_q <= 1'b0;
                    if (bus.tx_busy) begin
                        state_q <= TX_WAIT_DONE;
                    end else if (timer_q == TMR_W'(ACK_TIMEOUT)) begin
                        // The byte is treated as consumed; the host sees tx_error instead.
                        tx_error_q <= 1'b1;
                        state_q    <= TX_IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                TX_WAIT_DONE: begin
                    if (!bus.tx_busy)
                        state_q <= TX_IDLE;
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.count    = fifo_used;
    assign bus.overflow = overflow_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_error = tx_error_q;

endmodule

// File: tb/tb_uart_tx_fifo_controller.sv
// Scoreboard bench for uart_tx_fifo_controller: a uart_tx busy responder, a start/error monitor
// and a queue of bytes expected on the serializer in order.
module tb_uart_tx_fifo_controller;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int ACK    = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_tx_fifo_controller_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    uart_tx_fifo_controller #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W),
        .ACK_TIMEOUT (ACK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int starts = 0;
    int last_start_cyc = -100;
    int push_cyc = 0;
    int errs_seen = 0, errs_exp = 0;
    int ovf_seen  = 0, ovf_exp  = 0;
    int bmode = 0;       // 0: respond to tx_start, 1: busy forced high, 2: never busy
    int hold_fixed = 0;  // >0 fixes the busy duration, else random
    logic [DATA_W-1:0] exp_q[$];

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Serializer model: busy rises the cycle after tx_start is seen and holds for a while.
    initial begin
        int  bcnt = 0;
        bit  pend = 0;
        bus.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bmode == 1) begin
                bus.tx_busy = 1'b1; bcnt = 0; pend = 0;
            end else if (bmode == 2) begin
                bus.tx_busy = 1'b0; bcnt = 0; pend = 0;
            end else if (pend) begin
                bus.tx_busy = 1'b1;
                bcnt = (hold_fixed > 0) ? hold_fixed : int'($urandom_range(1, 8));
                pend = 0;
            end else if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) bus.tx_busy = 1'b0;
            end else begin
                bus.tx_busy = 1'b0;
                if (bus.tx_start) pend = 1;
            end
        end
    end

    // Monitor: every tx_start pops the next expected byte.
    initial begin
        logic prev_start = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (bus.tx_start) begin
                starts++;
                last_start_cyc = cyc;
                chk("start_pulse_width", int'(prev_start), 0);
                chk("start_while_busy", int'(bus.tx_busy), 0);
                if (exp_q.size() == 0) chk("unexpected_start", exp_q.size(), 1);
                else chk("tx_data", int'(bus.tx_data), int'(exp_q.pop_front()));
            end
            if (bus.tx_error) begin
                errs_seen++;
                chk("error_latency", cyc - last_start_cyc, ACK + 1);
            end
            if (bus.overflow) ovf_seen++;
            prev_start = bus.tx_start;
        end
    end

    task automatic push_byte(input logic [DATA_W-1:0] b);
        @(negedge clk);
        bus.write = 1'b1;
        bus.data  = b;
        push_cyc  = cyc + 1;
        @(negedge clk);
        bus.write = 1'b0;
    endtask

    task automatic set_bmode(input int m);
        @(posedge clk);
        #3;
        bmode = m;
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while ((exp_q.size() != 0 || bus.tx_busy || (cyc - last_start_cyc) < 4) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", int'(n < bound), 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got=running expected=done");
        $fatal(1);
    end

    initial begin
        int s0, n, occ;
        logic [DATA_W-1:0] b;
        bus.write = 1'b1;
        bus.data  = '0;

        // Reset values, then release with write held high
        repeat (3) @(negedge clk);
        chk("rst_count", int'(bus.count), 0);
        chk("rst_empty", int'(bus.empty), 1);
        chk("rst_full", int'(bus.full), 0);
        chk("rst_tx_start", int'(bus.tx_start), 0);
        chk("rst_tx_data", int'(bus.tx_data), 0);
        chk("rst_overflow", int'(bus.overflow), 0);
        chk("rst_tx_error", int'(bus.tx_error), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        bus.write = 1'b0;
        repeat (10) @(negedge clk);
        chk("held_write_count", int'(bus.count), 0);
        chk("held_write_empty", int'(bus.empty), 1);
        chk("held_write_starts", starts, 0);

        // Single byte, busy held 20 cycles
        hold_fixed = 20;
        s0 = starts;
        exp_q.push_back(8'h41);
        push_byte(8'h41);
        n = 0;
        while (starts == s0 && n < 20) begin @(negedge clk); n++; end
        chk("first_start_seen", int'(starts > s0), 1);
        chk("start_latency", last_start_cyc - push_cyc, 2);
        repeat (3) @(negedge clk);
        chk("single_count", int'(bus.count), 0);
        chk("single_empty", int'(bus.empty), 1);
        wait_drain(100);
        hold_fixed = 0;

        // Fill while the serializer is busy, then one more
        set_bmode(1);
        repeat (2) @(negedge clk);
        occ = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = (i < DEPTH) ? 8'(i) : 8'hFF;
            if (occ < DEPTH) begin exp_q.push_back(b); occ++; end
            else ovf_exp++;
            push_byte(b);
            if (i == DEPTH - 1) begin
                chk("fill_count", int'(bus.count), DEPTH);
                chk("fill_full", int'(bus.full), 1);
            end
        end
        repeat (2) @(negedge clk);
        chk("overflow_pulses", ovf_seen, ovf_exp);
        chk("overflow_count", int'(bus.count), DEPTH);

        // Release busy and push on the pop edge while full
        set_bmode(0);
        @(negedge clk);
        bus.write = 1'b1;
        bus.data  = 8'hAA;
        exp_q.push_back(8'hAA);
        @(negedge clk);
        bus.write = 1'b0;
        chk("pushpop_count", int'(bus.count), DEPTH);
        chk("pushpop_full", int'(bus.full), 1);
        @(negedge clk);
        chk("pushpop_overflow", ovf_seen, ovf_exp);
        wait_drain(2000);
        chk("drain_count", int'(bus.count), 0);
        chk("drain_empty", int'(bus.empty), 1);

        // Random bursts, never deep enough to overflow
        for (int k = 0; k < 4; k++) begin
            n = int'($urandom_range(1, 10));
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom_range(0, 255));
                exp_q.push_back(b);
                push_byte(b);
                repeat ($urandom_range(0, 4)) @(negedge clk);
            end
            wait_drain(1000);
            chk("burst_count", int'(bus.count), 0);
        end

        // Serializer never acknowledges
        set_bmode(2);
        @(negedge clk);
        exp_q.push_back(8'h55);
        errs_exp++;
        push_byte(8'h55);
        n = 0;
        while (errs_seen < errs_exp && n < 60) begin @(negedge clk); n++; end
        chk("timeout_error_seen", errs_seen, errs_exp);
        chk("timeout_count", int'(bus.count), 0);
        chk("timeout_empty", int'(bus.empty), 1);
        set_bmode(0);
        exp_q.push_back(8'h66);
        push_byte(8'h66);
        wait_drain(100);

        // Async reset while a transfer is in progress with 5 bytes queued
        hold_fixed = 40;
        s0 = starts;
        exp_q.push_back(8'h10);
        push_byte(8'h10);
        n = 0;
        while (starts == s0 && n < 20) begin @(negedge clk); n++; end
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(8'(8'h10 + i));
            push_byte(8'(8'h10 + i));
        end
        chk("queued_count", int'(bus.count), 5);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_count", int'(bus.count), 0);
        chk("async_rst_empty", int'(bus.empty), 1);
        chk("async_rst_tx_start", int'(bus.tx_start), 0);
        chk("async_rst_tx_data", int'(bus.tx_data), 0);
        exp_q.delete();
        hold_fixed = 0;
        set_bmode(2);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        set_bmode(0);
        exp_q.push_back(8'h77);
        push_byte(8'h77);
        wait_drain(100);

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("error_total", errs_seen, errs_exp);
        chk("overflow_total", ovf_seen, ovf_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo_controller.md
Name: uart_tx_fifo_controller

Overview:
Transmit-side counterpart of the UART receive FIFO controller. It accepts bytes from the host logic, one byte per rising edge of a write request. Bytes are buffered in an internal FIFO and drained one at a time into the UART transmitter using a start-pulse / busy handshake. It sits between the command/host logic and the uart_tx serializer.

Parameters:
DATA_W, 8, byte width
DEPTH, 16, FIFO entries; power of two
ADDR_W, 4, log2(DEPTH)
ACK_TIMEOUT, 15, max cycles to wait for tx_busy to rise after tx_start

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  reset; asynchronous, active-high
write  input  1  host write request; level, one push per rising edge
data  input  DATA_W  byte to enqueue; sampled on the push edge
full  output  1  FIFO holds DEPTH entries
empty  output  1  FIFO holds 0 entries
count  output  ADDR_W+1  current occupancy, 0..DEPTH
overflow  output  1  1-cycle pulse: push dropped because FIFO was full
tx_busy  input  1  serializer busy flag from uart_tx
tx_start  output  1  1-cycle pulse: start transmitting tx_data
tx_data  output  DATA_W  byte presented to uart_tx; held stable until the next load
tx_error  output  1  1-cycle pulse: ACK_TIMEOUT expired waiting for tx_busy

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, pointers=0, count=0, empty=1, full=0.
  - tx_start=0, tx_data=0, overflow=0, tx_error=0.
  - write_q=1, so a write held high across reset release does not push.
  - Reset mid-transfer discards FIFO contents and aborts the handshake.
- Push:
  - push = write & ~write_q; write_q is registered every cycle.
  - On a push edge with full=0, data is stored at wr_ptr and wr_ptr increments mod DEPTH.
  - On a push edge with full=1 and no simultaneous pop, the byte is dropped and overflow=1 for the next cycle only.
- Pop: asserted internally by the FSM only when empty=0. The FIFO read output is registered, so the byte is valid one cycle after the pop.
- Simultaneous push and pop:
  - Both proceed and count is unchanged.
  - When full, the pop frees the slot, so the push is accepted and there is no overflow.
  - When empty, there is no bypass: the push is stored and the pop is not issued that cycle.
- count, full and empty are registered and updated on the same edge as the pointers. full = (count==DEPTH); empty = (count==0).
- FSM, states IDLE, LOAD, WAIT_BUSY, WAIT_DONE:
  - IDLE: if empty=0 and tx_busy=0, issue pop and go to LOAD; otherwise stay.
  - LOAD: tx_data <= FIFO output, tx_start <= 1, timer <= 0; go to WAIT_BUSY.
  - WAIT_BUSY:
    - tx_start <= 0 (so the pulse lasts exactly one cycle).
    - If tx_busy=1, go to WAIT_DONE.
    - Else if timer==ACK_TIMEOUT, tx_error <= 1 for 1 cycle, byte counted as consumed, go to IDLE.
    - Else timer increments.
  - WAIT_DONE: when tx_busy=0, go to IDLE.
- Latency, empty FIFO and idle transmitter:
  - Push on edge E0; pop on E1.
  - tx_data and tx_start=1 registered on E2.
  - tx_start returns to 0 on E3.
- Back-to-back bytes: the next pop occurs no earlier than the cycle after tx_busy falls, i.e. the first IDLE cycle.
- Pointer wrap: wr_ptr/rd_ptr are ADDR_W bits and wrap naturally from DEPTH-1 to 0.

Decomposition:
- Shared package uart_pkg:
  - DATA_W default.
  - FSM state encoding constants TX_IDLE, TX_LOAD, TX_WAIT_BUSY, TX_WAIT_DONE (2-bit).
  - ACK_TIMEOUT default.
- One sub-module, sync_fifo:
  - Parameters DATA_W, DEPTH, ADDR_W; ports clk, rst, wrreq, data, rdreq, q, empty, full, usedw.
  - Registered q; it replaces vendor FIFO IP so the block is portable.
- The edge detector, FSM and timeout counter stay in the top module.

Test Plan:
- Reset release with write held high, then idle for 10 cycles -> no push, count=0, empty=1, tx_start never asserted.
- Single write pulse with data=0x41, tx_busy model rising 1 cycle after tx_start and held for 20 cycles -> tx_start pulses exactly 2 cycles after the push edge with tx_data=0x41; count returns to 0; no second tx_start until tx_busy falls.
- 16 pushes (0x00..0x0F) while tx_busy is held at 1, then a 17th push of 0xFF -> full=1, count=16, overflow pulses once, 0xFF absent. On release, bytes arrive in order 0x00..0x0F across a pointer wrap.
- FIFO full in IDLE, pop and push on the same edge with data=0xAA -> count stays 16, no overflow, 0xAA later emitted last.
- tx_busy tied to 0 after a push of 0x55 -> tx_error pulses 16 cycles after tx_start (ACK_TIMEOUT=15); FSM returns to IDLE; count=0.
- rst asserted mid-WAIT_DONE with 5 bytes queued -> outputs clear immediately (asynchronous); count=0, empty=1, tx_start=0, tx_data=0.
